// File: rtl/lap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lap_pkg                                                    |
// | Description : Shared widths, radix constants and the lap time record     |
// |               used by the lap time buffer and its split subtractor.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lap_pkg;

    localparam int SUB_SEC_W = 7;
    localparam int SEC_W     = 6;
    localparam int MIN_W     = 6;
    localparam int HOUR_W    = 7;
    localparam int TIME_W    = HOUR_W + MIN_W + SEC_W + SUB_SEC_W;

    localparam int MAX_SUB_SEC = 100;
    localparam int MAX_SEC     = 60;
    localparam int MAX_MIN     = 60;
    localparam int MAX_HOUR    = 100;

    typedef struct packed {
        logic [HOUR_W-1:0]    hour;
        logic [MIN_W-1:0]     min;
        logic [SEC_W-1:0]     sec;
        logic [SUB_SEC_W-1:0] sub_sec;
    } lap_time_t;

endpackage
`default_nettype wire

// File: rtl/lap_split_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lap_split_sub                                              |
// | Description : Combinational mixed-radix subtractor, o_diff = i_a - i_b.  |
// |               Fields borrow through 100 / 60 / 60 / 100; a negative      |
// |               hour result wraps modulo 100 hours.                        |
// | Ports       : i_a, i_b  lap_time_t operands                              |
// |               o_diff    lap_time_t difference                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lap_split_sub
    import lap_pkg::*;
(
    input  lap_time_t i_a,
    input  lap_time_t i_b,
    output lap_time_t o_diff
);

    // Each difference is one bit wider than its field; the MSB is the sign,
    // which doubles as the borrow into the next field.
    logic [SUB_SEC_W:0] w_ss_diff;
    logic [SEC_W:0]     w_s_diff;
    logic [MIN_W:0]     w_m_diff;
    logic [HOUR_W:0]    w_h_diff;

    assign w_ss_diff = {1'b0, i_a.sub_sec} - {1'b0, i_b.sub_sec};
    assign w_s_diff  = {1'b0, i_a.sec} - {1'b0, i_b.sec}
                     - {{SEC_W{1'b0}}, w_ss_diff[SUB_SEC_W]};
    assign w_m_diff  = {1'b0, i_a.min} - {1'b0, i_b.min}
                     - {{MIN_W{1'b0}}, w_s_diff[SEC_W]};
    assign w_h_diff  = {1'b0, i_a.hour} - {1'b0, i_b.hour}
                     - {{HOUR_W{1'b0}}, w_m_diff[MIN_W]};

    assign o_diff.sub_sec = w_ss_diff[SUB_SEC_W]
                          ? SUB_SEC_W'(w_ss_diff + (SUB_SEC_W+1)'(MAX_SUB_SEC))
                          : w_ss_diff[SUB_SEC_W-1:0];
    assign o_diff.sec     = w_s_diff[SEC_W]
                          ? SEC_W'(w_s_diff + (SEC_W+1)'(MAX_SEC))
                          : w_s_diff[SEC_W-1:0];
    assign o_diff.min     = w_m_diff[MIN_W]
                          ? MIN_W'(w_m_diff + (MIN_W+1)'(MAX_MIN))
                          : w_m_diff[MIN_W-1:0];
    // Final borrow is discarded: adding 100 gives the modulo-100h difference.
    assign o_diff.hour    = w_h_diff[HOUR_W]
                          ? HOUR_W'(w_h_diff + (HOUR_W+1)'(MAX_HOUR))
                          : w_h_diff[HOUR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/lap_time_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lap_time_buffer                                            |
// | Description : Snapshots the stopwatch time on each lap strobe into a     |
// |               DEPTH-entry circular buffer drained via valid/ready.       |
// |               When full, a new lap overwrites the oldest (sticky oOVF).  |
// | Config      : define LAP_SPLIT_EN to compute and store split times;      |
// |               otherwise oSPLIT_* are tied to zero.                       |
// | Ports       : iCLK, iRESET (async, active-high), iCLEAR (sync clear)     |
// |               iLAP_STB, iSUB_SEC/iSEC/iMIN/iHOUR  lap capture            |
// |               iLAP_READY / oLAP_VALID             head handshake         |
// |               oLAP_NUM, oLAP_*, oSPLIT_*           head entry fields     |
// |               oCOUNT, oOVF                         occupancy, overwrite  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lap_time_buffer
    import lap_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int LAPNUM_W = 8
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iCLEAR,
    input  logic                    iLAP_STB,
    input  logic [SUB_SEC_W-1:0]    iSUB_SEC,
    input  logic [SEC_W-1:0]        iSEC,
    input  logic [MIN_W-1:0]        iMIN,
    input  logic [HOUR_W-1:0]       iHOUR,
    input  logic                    iLAP_READY,
    output logic                    oLAP_VALID,
    output logic [LAPNUM_W-1:0]     oLAP_NUM,
    output logic [SUB_SEC_W-1:0]    oLAP_SUB_SEC,
    output logic [SEC_W-1:0]        oLAP_SEC,
    output logic [MIN_W-1:0]        oLAP_MIN,
    output logic [HOUR_W-1:0]       oLAP_HOUR,
    output logic [SUB_SEC_W-1:0]    oSPLIT_SUB_SEC,
    output logic [SEC_W-1:0]        oSPLIT_SEC,
    output logic [MIN_W-1:0]        oSPLIT_MIN,
    output logic [HOUR_W-1:0]       oSPLIT_HOUR,
    output logic [$clog2(DEPTH):0]  oCOUNT,
    output logic                    oOVF
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    lap_time_t             r_mem_time [DEPTH];
    logic [LAPNUM_W-1:0]   r_mem_num  [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [LAPNUM_W-1:0]   r_lap_cnt;
    logic                  r_ovf;

    lap_time_t w_cur;
    lap_time_t w_head_time;
    logic      w_empty;
    logic      w_full;
    logic      w_push;
    logic      w_pop;
    logic      w_drop;

    assign w_cur   = '{hour: iHOUR, min: iMIN, sec: iSEC, sub_sec: iSUB_SEC};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // Clear squashes any push or pop presented in the same cycle.
    assign w_push  = iLAP_STB && !iCLEAR;
    assign w_pop   = iLAP_READY && !w_empty && !iCLEAR;
    // Full and nobody reading: the oldest entry is sacrificed for the new one.
    assign w_drop  = w_push && w_full && !w_pop;

    // Storage carries no reset; the empty mux on the head hides stale data.
    always_ff @(posedge iCLK) begin
        if (w_push && !iRESET) begin
            r_mem_time[r_wr_ptr] <= w_cur;
            r_mem_num[r_wr_ptr]  <= r_lap_cnt + LAPNUM_W'(1);
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_lap_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (iCLEAR) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_lap_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
                r_lap_cnt <= r_lap_cnt + LAPNUM_W'(1);
            end
            if (w_pop || w_drop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_head_time  = w_empty ? '0 : r_mem_time[r_rd_ptr];
    assign oLAP_VALID   = !w_empty;
    assign oLAP_NUM     = w_empty ? '0 : r_mem_num[r_rd_ptr];
    assign oLAP_SUB_SEC = w_head_time.sub_sec;
    assign oLAP_SEC     = w_head_time.sec;
    assign oLAP_MIN     = w_head_time.min;
    assign oLAP_HOUR    = w_head_time.hour;
    assign oCOUNT       = r_count;
    assign oOVF         = r_ovf;

`ifdef LAP_SPLIT_EN
    lap_time_t r_prev;
    lap_time_t r_mem_split [DEPTH];
    lap_time_t w_split;
    lap_time_t w_head_split;

    lap_split_sub u_split (
        .i_a    (w_cur),
        .i_b    (r_prev),
        .o_diff (w_split)
    );

    always_ff @(posedge iCLK) begin
        if (w_push && !iRESET) begin
            r_mem_split[r_wr_ptr] <= w_split;
        end
    end

    // Reference starts at zero so the first lap's split is its cumulative time.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_prev <= '0;
        end else if (iCLEAR) begin
            r_prev <= '0;
        end else if (w_push) begin
            r_prev <= w_cur;
        end
    end

    assign w_head_split   = w_empty ? '0 : r_mem_split[r_rd_ptr];
    assign oSPLIT_SUB_SEC = w_head_split.sub_sec;
    assign oSPLIT_SEC     = w_head_split.sec;
    assign oSPLIT_MIN     = w_head_split.min;
    assign oSPLIT_HOUR    = w_head_split.hour;
`else
    assign oSPLIT_SUB_SEC = '0;
    assign oSPLIT_SEC     = '0;
    assign oSPLIT_MIN     = '0;
    assign oSPLIT_HOUR    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lap_time_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lap_time_buffer                                         |
// | Description : Scoreboard bench for lap_time_buffer. Expected entries are |
// |               queued as laps are strobed and compared at the head.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lap_time_buffer;

    localparam int DEPTH   = 8;
    localparam int CS_WRAP = 100 * 3600 * 100;   // 100 hours in centiseconds

    logic       iCLK = 1'b0;
    logic       iRESET = 1'b1;
    logic       iCLEAR = 1'b0;
    logic       iLAP_STB = 1'b0;
    logic [6:0] iSUB_SEC = '0;
    logic [5:0] iSEC = '0;
    logic [5:0] iMIN = '0;
    logic [6:0] iHOUR = '0;
    logic       iLAP_READY = 1'b0;
    logic       oLAP_VALID;
    logic [7:0] oLAP_NUM;
    logic [6:0] oLAP_SUB_SEC;
    logic [5:0] oLAP_SEC;
    logic [5:0] oLAP_MIN;
    logic [6:0] oLAP_HOUR;
    logic [6:0] oSPLIT_SUB_SEC;
    logic [5:0] oSPLIT_SEC;
    logic [5:0] oSPLIT_MIN;
    logic [6:0] oSPLIT_HOUR;
    logic [3:0] oCOUNT;
    logic       oOVF;

    lap_time_buffer #(.DEPTH(DEPTH), .LAPNUM_W(8)) u_dut (
        .iCLK           (iCLK),
        .iRESET         (iRESET),
        .iCLEAR         (iCLEAR),
        .iLAP_STB       (iLAP_STB),
        .iSUB_SEC       (iSUB_SEC),
        .iSEC           (iSEC),
        .iMIN           (iMIN),
        .iHOUR          (iHOUR),
        .iLAP_READY     (iLAP_READY),
        .oLAP_VALID     (oLAP_VALID),
        .oLAP_NUM       (oLAP_NUM),
        .oLAP_SUB_SEC   (oLAP_SUB_SEC),
        .oLAP_SEC       (oLAP_SEC),
        .oLAP_MIN       (oLAP_MIN),
        .oLAP_HOUR      (oLAP_HOUR),
        .oSPLIT_SUB_SEC (oSPLIT_SUB_SEC),
        .oSPLIT_SEC     (oSPLIT_SEC),
        .oSPLIT_MIN     (oSPLIT_MIN),
        .oSPLIT_HOUR    (oSPLIT_HOUR),
        .oCOUNT         (oCOUNT),
        .oOVF           (oOVF)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [7:0] num;
        int         cum;
        int         split;
    } ent_t;

    ent_t       sb_q[$];
    bit         m_ovf;
    logic [7:0] m_lap;
    int         m_prev;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] to_t(input int cs);
        to_t = {7'(cs / 360000), 6'((cs / 6000) % 60), 6'((cs / 100) % 60), 7'(cs % 100)};
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_lap  = '0;
        m_prev = 0;
    endtask

    task automatic check_head(input string tag);
        bit          e_valid;
        logic [7:0]  e_num;
        logic [25:0] e_cum;
        logic [25:0] e_split;
        e_valid = 1'b0;
        e_num   = '0;
        e_cum   = '0;
        e_split = '0;
        if (sb_q.size() > 0) begin
            e_valid = 1'b1;
            e_num   = sb_q[0].num;
            e_cum   = to_t(sb_q[0].cum);
`ifdef LAP_SPLIT_EN
            e_split = to_t(sb_q[0].split);
`endif
        end
        chk({tag, ".valid"}, 32'(oLAP_VALID), 32'(e_valid));
        chk({tag, ".count"}, 32'(oCOUNT), 32'(sb_q.size()));
        chk({tag, ".ovf"},   32'(oOVF), 32'(m_ovf));
        chk({tag, ".num"},   32'(oLAP_NUM), 32'(e_num));
        chk({tag, ".cum"},   32'({oLAP_HOUR, oLAP_MIN, oLAP_SEC, oLAP_SUB_SEC}), 32'(e_cum));
        chk({tag, ".split"}, 32'({oSPLIT_HOUR, oSPLIT_MIN, oSPLIT_SEC, oSPLIT_SUB_SEC}), 32'(e_split));
    endtask

    // Drive one clock of stimulus, advance the scoreboard, return #1 after the edge.
    task automatic cyc(input bit stb, input int t_cs, input bit rdy, input bit clr);
        ent_t e;
        iLAP_STB   = stb;
        iLAP_READY = rdy;
        iCLEAR     = clr;
        {iHOUR, iMIN, iSEC, iSUB_SEC} = to_t(t_cs);
        if (clr) begin
            model_reset();
        end else begin
            if (rdy && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            if (stb) begin
                if (sb_q.size() == DEPTH) begin
                    void'(sb_q.pop_front());
                    m_ovf = 1'b1;
                end
                m_lap   = m_lap + 8'd1;
                e.num   = m_lap;
                e.cum   = t_cs;
                e.split = (t_cs - m_prev + CS_WRAP) % CS_WRAP;
                m_prev  = t_cs;
                sb_q.push_back(e);
            end
        end
        @(posedge iCLK);
        #1;
        iLAP_STB   = 1'b0;
        iLAP_READY = 1'b0;
        iCLEAR     = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            check_head(tag);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        check_head({tag, ".empty"});
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        check_head("rst_held");
        iRESET = 1'b0;
        check_head("rst");

        // Basic capture and pop
        cyc(1'b1, 150, 1'b0, 1'b0);
        cyc(1'b1, 320, 1'b0, 1'b0);
        check_head("basic_two");
        cyc(1'b0, 0, 1'b1, 1'b0);
        check_head("basic_pop");
        drain("basic_drain");

        // Borrow through seconds and minutes
        cyc(1'b1, (1 * 60 + 59) * 100 + 90, 1'b0, 1'b0);
        cyc(1'b1, (2 * 60) * 100 + 10, 1'b0, 1'b0);
        drain("borrow_min");
        // Hour wrap
        cyc(1'b1, 99 * 360000 + 59 * 6000 + 5999, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b0, 1'b0);
        drain("borrow_hour");

        // Overflow: ten laps with no reads
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 100 * (i + 1) + 7 * i, 1'b0, 1'b0);
        check_head("ovf_full");
        drain("ovf_drain");

        // Push and pop together while full; clear also drops the sticky flag
        cyc(1'b0, 0, 1'b0, 1'b1);
        check_head("clr_ovf");
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 6000 + 123 * i, 1'b0, 1'b0);
        check_head("full");
        cyc(1'b1, 9999, 1'b1, 1'b0);
        check_head("full_pushpop");
        drain("full_drain");
        cyc(1'b0, 0, 1'b1, 1'b0);
        check_head("pop_empty");

        // Clear wins over a simultaneous strobe
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 500 + 41 * i, 1'b0, 1'b0);
        check_head("pre_clr");
        cyc(1'b1, 777, 1'b1, 1'b1);
        check_head("clr_stb");
        cyc(1'b1, 4321, 1'b0, 1'b0);
        check_head("post_clr");
        drain("post_clr_drain");

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) cyc(1'b1, 20000 + 313 * i, 1'b0, 1'b0);
        check_head("pre_rst");
        #2;
        iRESET = 1'b1;
        #1;
        model_reset();
        check_head("async_rst");
        @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        cyc(1'b1, 250, 1'b0, 1'b0);
        check_head("post_rst");
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
